// File: rtl/shift_pipe_barrel_valid_ready_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_pipe_barrel_valid_ready_if
// Purpose  : Upstream and downstream valid/ready bundle for the pipelined
//            barrel shifter.
// Signals  : up_valid/up_ready/up_data/up_shamt/up_dir/up_arith  (upstream)
//            down_valid/down_ready/down_data/down_lost           (downstream)
// Modports : slave  - the shifter (consumes up_*, produces down_*)
//            master - the environment driving and draining the shifter
// Revision : 1.0 - initial release
// ============================================================================
interface shift_pipe_barrel_valid_ready_if #(
  parameter int N = 8
);
  localparam int SW = $clog2(N);

  logic          up_valid;
  logic          up_ready;
  logic [N-1:0]  up_data;
  logic [SW-1:0] up_shamt;
  logic          up_dir;
  logic          up_arith;
  logic          down_valid;
  logic          down_ready;
  logic [N-1:0]  down_data;
  logic          down_lost;

  modport slave (
    input  up_valid, up_data, up_shamt, up_dir, up_arith, down_ready,
    output up_ready, down_valid, down_data, down_lost
  );

  modport master (
    output up_valid, up_data, up_shamt, up_dir, up_arith, down_ready,
    input  up_ready, down_valid, down_data, down_lost
  );
endinterface
`default_nettype wire

// File: rtl/shift_pipe_barrel_valid_ready.sv
`default_nettype none
// ============================================================================
// Module   : shift_pipe_barrel_valid_ready
// Purpose  : Pipelined logarithmic barrel shifter with valid/ready on both
//            sides. Stage k applies shift-amount bit k (shift by 2^k), so
//            latency is $clog2(N) register stages at one item per cycle.
//            A sticky lost flag reports whether any 1 was shifted out.
// Ports    : clk   - clock, rising edge
//            rst_n - asynchronous active-low reset
//            bus   - slave side of shift_pipe_barrel_valid_ready_if
//                    (up_* operand/control in, down_* result out)
// Notes    : N must be a power of two and >= 2.
// Revision : 1.0 - initial release
// ============================================================================
module shift_pipe_barrel_valid_ready #(
  parameter int N = 8
) (
  input  wire logic                      clk,
  input  wire logic                      rst_n,
  shift_pipe_barrel_valid_ready_if.slave bus
);
  localparam int            SW         = $clog2(N);
  localparam logic [N-1:0]  c_all_ones = {N{1'b1}};

  // Stage registers; index k is the output register of stage k.
  logic          r_valid [SW];
  logic [N-1:0]  r_data  [SW];
  logic          r_lost  [SW];
  logic          r_dir   [SW];
  logic          r_fill  [SW];
  logic [SW-1:0] r_shamt [SW];

  // Stage inputs and shifted next values.
  logic          w_in_valid [SW];
  logic [N-1:0]  w_in_data  [SW];
  logic          w_in_lost  [SW];
  logic          w_in_dir   [SW];
  logic          w_in_fill  [SW];
  logic [SW-1:0] w_in_shamt [SW];
  logic [N-1:0]  w_nx_data  [SW];
  logic          w_nx_lost  [SW];
  logic          w_ready    [SW];
  logic          w_chain;

  always_comb begin
    // Stage 0 sees the upstream port. The fill bit is resolved once here:
    // only a right arithmetic shift of a negative operand fills with ones.
    w_in_valid[0] = bus.up_valid;
    w_in_data[0]  = bus.up_data;
    w_in_lost[0]  = 1'b0;
    w_in_dir[0]   = bus.up_dir;
    w_in_fill[0]  = bus.up_dir & bus.up_arith & bus.up_data[N-1];
    w_in_shamt[0] = bus.up_shamt;
    for (int k = 1; k < SW; k++) begin
      w_in_valid[k] = r_valid[k-1];
      w_in_data[k]  = r_data[k-1];
      w_in_lost[k]  = r_lost[k-1];
      w_in_dir[k]   = r_dir[k-1];
      w_in_fill[k]  = r_fill[k-1];
      w_in_shamt[k] = r_shamt[k-1];
    end

    for (int k = 0; k < SW; k++) begin
      w_nx_data[k] = w_in_data[k];
      w_nx_lost[k] = w_in_lost[k];
      if (w_in_shamt[k][k]) begin
        if (w_in_dir[k]) begin
          // Right: bottom 2^k bits leave; top 2^k bits take the fill value.
          w_nx_data[k] = (w_in_data[k] >> (1 << k)) |
                         (w_in_fill[k] ? ~(c_all_ones >> (1 << k)) : '0);
          w_nx_lost[k] = w_in_lost[k] |
                         (|(w_in_data[k] & ~(c_all_ones << (1 << k))));
        end else begin
          // Left: top 2^k bits leave; zeros enter at the bottom.
          w_nx_data[k] = w_in_data[k] << (1 << k);
          w_nx_lost[k] = w_in_lost[k] |
                         (|(w_in_data[k] & ~(c_all_ones >> (1 << k))));
        end
      end
    end
  end

  // A stage can load when empty or when its item moves on this cycle.
  // Walked from the output back so each ready depends only on valids
  // and down_ready, never on up_valid.
  always_comb begin
    w_chain = bus.down_ready;
    for (int k = SW - 1; k >= 0; k--) begin
      w_chain    = !r_valid[k] || w_chain;
      w_ready[k] = w_chain;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SW; k++) begin
        r_valid[k] <= 1'b0;
        r_data[k]  <= '0;
        r_lost[k]  <= 1'b0;
        r_dir[k]   <= 1'b0;
        r_fill[k]  <= 1'b0;
        r_shamt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < SW; k++) begin
        if (w_ready[k]) begin
          r_valid[k] <= w_in_valid[k];
          // Payload only moves with a real item so a drained stage keeps
          // its last contents instead of picking up junk.
          if (w_in_valid[k]) begin
            r_data[k]  <= w_nx_data[k];
            r_lost[k]  <= w_nx_lost[k];
            r_dir[k]   <= w_in_dir[k];
            r_fill[k]  <= w_in_fill[k];
            r_shamt[k] <= w_in_shamt[k];
          end
        end
      end
    end
  end

  assign bus.up_ready   = w_ready[0];
  assign bus.down_valid = r_valid[SW-1];
  assign bus.down_data  = r_data[SW-1];
  assign bus.down_lost  = r_lost[SW-1];

endmodule
`default_nettype wire

// File: doc/shift_pipe_barrel_valid_ready.md
Name: shift_pipe_barrel_valid_ready

Overview:
- Pipelined logarithmic barrel shifter. Variable shift amount, left/right, logical/arithmetic.
- Valid/ready on both sides; sits downstream of the fixed-shift combinational blocks in the arithmetics section and generalises them to a runtime amount.
- One register stage per shift-amount bit: throughput of one item per cycle, latency $clog2(N) cycles.
- Sticky "lost bits" flag for rounding logic further downstream.

Parameters:
- N, 8, data width; must be a power of two and >= 2.
- (derived localparam) SW = $clog2(N), shift-amount width and number of pipeline stages.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- up_valid  input  1  upstream item present.
- up_ready  output  1  block accepts the item this cycle.
- up_data  input  N  operand.
- up_shamt  input  SW  shift amount, 0..N-1.
- up_dir  input  1  0 = left, 1 = right.
- up_arith  input  1  1 = arithmetic (sign fill); only meaningful when up_dir = 1, ignored for left.
- down_valid  output  1  result present.
- down_ready  input  1  downstream accepts result.
- down_data  output  N  shifted result.
- down_lost  output  1  OR of every bit shifted out of the word.

Behaviour:
- Reset:
  - rst_n low asynchronously clears all stage valid flags, data, control and lost registers to 0.
  - down_valid = 0, down_data = 0, down_lost = 0 while rst_n is low.
  - Items in flight are discarded; no output results from them after reset.
- Stage k (k = 0..SW-1) owns shift-amount bit k:
  - Registers data, remaining shamt bits, dir, arith, sign, lost and a valid flag.
  - If shamt bit k = 1, shifts by 2^k; otherwise passes data through unchanged.
  - Stage 0 consumes the up_* inputs; stage SW-1 drives down_*.
- Fill rules:
  - Left shift and right logical: fill with 0.
  - Right arithmetic: fill with the sign bit, which is up_data[N-1] captured at stage 0.
- lost:
  - Stage 0 starts at 0.
  - Each stage ORs in the bits it shifts out: top 2^k bits for left, bottom 2^k bits for right.
  - Result equals "any 1 discarded"; sign-fill bits never count.
- Handshake:
  - Transfer on each side occurs when valid && ready at the rising clk edge.
  - Stage k may load when it is empty or its contents leave this cycle: ready_k = !valid_k || ready_(k+1), with ready_SW = down_ready.
  - up_ready = ready_0. This is combinational from down_ready through the chain; there is no combinational path from up_valid to up_ready.
  - Bubbles collapse: an empty stage loads even while downstream is stalled.
  - down_valid, once asserted, stays high and down_data/down_lost stay stable until down_ready is sampled high.
  - Items leave in the order they were accepted; none are dropped or duplicated.
- Latency and throughput:
  - An item accepted at edge t appears with down_valid = 1 after edge t+SW-1 when there are no stalls. For N=8 it is visible 3 cycles after acceptance.
  - Sustained throughput is 1 item per cycle when down_ready stays high.
- Shift amount: up_shamt = 0 gives down_data = up_data and down_lost = 0. No shift amount of N or more is representable.
- Simultaneous events: a stage that is both emptied and loaded in the same cycle holds the new item afterwards; the old item has moved downstream.

Test Plan:
- N=8, down_ready=1: a=8'b1011_0110, shamt=3, dir=0 -> after 3 cycles down_data=8'b1011_0000, down_lost=1.
- Same a, shamt=3, dir=1, arith=0 -> down_data=8'b0001_0110, lost=1. With arith=1 -> down_data=8'b1111_0110, lost=1.
- Shift amount edge cases:
  - a=8'h81, shamt=0, either dir -> down_data=8'h81, lost=0.
  - a=8'h80, shamt=7, right arith -> 8'hFF, lost=0.
  - a=8'h01, shamt=7, left -> 8'h80, lost=0.
- Backpressure, down_ready=0: offer 4 items back-to-back -> exactly 3 accepted, up_ready=0 on the 4th. Raise down_ready -> 4 results in acceptance order on consecutive cycles, each matching the golden a<<s / a>>s / $signed(a)>>>s.
- Random stress, 2000 items: random up_valid and down_ready, random data/shamt/dir/arith -> a scoreboard matches every result and lost flag, with zero drops or duplicates.
- Reset mid-operation: 3 items in flight, pulse rst_n low between clock edges -> down_valid drops to 0 immediately with no clk edge needed. After release, none of the 3 items appear; a new item completes normally in 3 cycles.
